led_pattern_ctrl: RTL and testbench
===================================

# led_pattern_ctrl

Upstream control stage for the LED pattern sequencer. Conditions two raw on-board push buttons (synchronise, debounce, press-detect), turns them into a registered pattern-mode select and step-rate select, and generates the single-cycle step tick that advances the sequencer. The sequencer consumes `Mode`, `Mode_Changed` and `Step_Tick` and no longer runs its own delay counter.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable samples (20 ms at 50 MHz) before a button level is accepted.
- `TICK_DIV_BASE`, 6_250_000: step period in cycles at speed level 0 (8 Hz).
- `NUM_MODES`, 2: number of pattern modes; legal range 1..4.

- `Clk_50MHz`  in  1  system clock, 50 MHz.
- `Rst_OnBoard`  in  1  reset, asynchronous, active-high.
- `Btn_Mode_n`  in  1  raw mode button, active-low, asynchronous to clock.
- `Btn_Speed_n`  in  1  raw speed button, active-low, asynchronous to clock.
- `Mode`  out  2  current pattern mode, 0..NUM_MODES-1.
- `Mode_Changed`  out  1  one-cycle pulse in the cycle `Mode` takes a new value.
- `Speed_Lvl`  out  2  current speed level, 0..3.
- `Step_Tick`  out  1  one-cycle pulse; sequencer advances one step.

## Operation
- Reset values: `Mode`=0, `Mode_Changed`=0, `Speed_Lvl`=0, `Step_Tick`=0, divider=0. Synchroniser flops and debounced levels reset to 1 (released).
- Each button: 2-flop synchroniser, then debounce counter. Counter clears whenever the synced level equals the debounced level. Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced value and the counter clears.
- A press is a debounced 1->0 transition. It yields a one-cycle registered press pulse. Release causes no action. A held button yields exactly one press.
- Mode press: `Mode` <= (`Mode`==NUM_MODES-1) ? 0 : `Mode`+1. `Mode_Changed` is high in that same cycle. Divider clears to 0.
- Speed press: `Speed_Lvl` increments, wrapping 3->0. Divider clears to 0.
- Divider period P = TICK_DIV_BASE >> `Speed_Lvl` (8/16/32/64 Hz at defaults). Counter runs 0..P-1. `Step_Tick` is registered high in the cycle after the counter equals P-1; the counter then returns to 0.
- Both presses in the same cycle: both updates apply, divider clears once, `Mode_Changed` pulses.
- `Step_Tick` is forced low in any cycle where `Mode_Changed` is high. After a mode or speed change, the first tick comes a full new period P later.
- Reset mid-debounce or mid-period: all state returns to reset values immediately. A button held through reset release is not treated as a press until it is released and pressed again.

## Timing
- Press latency: after the first clock edge that samples the pin low, with a continuously low pin, `Mode`/`Speed_Lvl` update DEBOUNCE_CYCLES+3 edges later (2 synchroniser, DEBOUNCE_CYCLES debounce, 1 press register).
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no press.
- `Step_Tick` spacing is exactly P cycles in steady state. All outputs are registered, with no combinational input-to-output path.

## Configuration
- `LED_SPEED_SEL_EN` defined: speed button and speed levels behave as described.
- `LED_SPEED_SEL_EN` not defined: `Btn_Speed_n` is ignored and its debouncer is not instantiated. `Speed_Lvl` is tied to 0 and P = TICK_DIV_BASE. The port list is unchanged.

## Structure
- Package `led_ctrl_pkg` holds: mode width (2), speed width (2), the speed-level count (4), and the default DEBOUNCE_CYCLES and TICK_DIV_BASE constants.
- Sub-module `button_debounce` (synchroniser + debounce + press pulse) is instantiated once per button. The divider and mode/speed registers live in the top level.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, TICK_DIV_BASE=16, NUM_MODES=2.
- Reset, no buttons -> `Mode`=0, `Speed_Lvl`=0; `Step_Tick` pulses every 16 cycles, first pulse 16 cycles after the first post-reset edge.
- `Btn_Mode_n` low for 20 cycles -> `Mode` 0->1 exactly 7 edges after first low sample; `Mode_Changed` high one cycle; next `Step_Tick` 16 cycles later. Second press -> `Mode` wraps to 0.
- `Btn_Mode_n` low for 3 cycles, or bouncing 1-0-1-0 at 2-cycle intervals -> no `Mode` change, no `Mode_Changed`.
- Four speed presses -> `Step_Tick` spacing 8, 4, 2, then 16 (wrap), with `Speed_Lvl` 1, 2, 3, 0. Without `LED_SPEED_SEL_EN`, spacing stays 16.
- Both buttons pressed on the same edge -> `Mode` and `Speed_Lvl` both increment in the same cycle, single `Mode_Changed`, no `Step_Tick` in that cycle.
- `Rst_OnBoard` asserted mid-period with `Mode`=1, `Speed_Lvl`=2 -> all outputs 0 immediately, without waiting for a clock edge. `Btn_Mode_n` held low through reset release -> no press until released and re-pressed.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared widths and default timing constants for the LED pattern control stage.
// Contents: mode/speed widths, speed-level count, default debounce length and
// default step-divider base period, plus the matching field typedefs.
package led_ctrl_pkg;

    localparam int unsigned MODE_W              = 2;
    localparam int unsigned SPEED_W             = 2;
    localparam int unsigned SPEED_LVLS          = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;  // 20 ms at 50 MHz
    localparam int unsigned DEF_TICK_DIV_BASE   = 6_250_000;  // 8 Hz at 50 MHz

    typedef logic [MODE_W-1:0]  mode_t;
    typedef logic [SPEED_W-1:0] speed_t;

endpackage

// File: rtl/button_debounce.sv
// Conditions one raw active-low push button into a single-cycle press pulse.
// Ports:
//   clk_i     system clock
//   rst_i     asynchronous active-high reset
//   btn_n_i   raw button level, active-low, asynchronous to clk_i
//   press_o   registered one-cycle pulse on each debounced 1->0 transition
module button_debounce
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;     // [0] first stage, [1] synchronised level
    logic [1:0]       vld_q, vld_d;       // marks when sync_q[1] holds a post-reset sample
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;
    logic             deb_dly_q, deb_dly_d;
    logic             armed_q, armed_d;
    logic             press_q, press_d;

    // State registers; everything resets to the released level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= 2'b11;
            vld_q     <= 2'b00;
            cnt_q     <= '0;
            deb_q     <= 1'b1;
            deb_dly_q <= 1'b1;
            armed_q   <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            vld_q     <= vld_d;
            cnt_q     <= cnt_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            armed_q   <= armed_d;
            press_q   <= press_d;
        end
    end

    // Synchroniser, debounce counter and falling-edge press detect.
    always_comb begin
        sync_d    = {sync_q[0], btn_n_i};
        vld_d     = {vld_q[0], 1'b1};
        cnt_d     = '0;
        deb_d     = deb_q;
        deb_dly_d = deb_q;
        if (sync_q[1] != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // A button held through reset never arms until it is seen released,
        // so its first debounced low is not reported as a press.
        armed_d = armed_q | (vld_q[1] & sync_q[1]);
        press_d = armed_q & deb_dly_q & ~deb_q;
    end

    assign press_o = press_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Upstream control for the LED pattern sequencer: debounced mode/speed buttons,
// registered mode and speed-level selects, and the step-tick divider.
// Optional feature macro: LED_SPEED_SEL_EN (speed button enabled when defined;
// otherwise Btn_Speed_n is ignored, Speed_Lvl stays 0, period = TICK_DIV_BASE).
// Ports:
//   Clk_50MHz     system clock
//   Rst_OnBoard   asynchronous active-high reset
//   Btn_Mode_n    raw mode button, active-low
//   Btn_Speed_n   raw speed button, active-low
//   Mode          current pattern mode, 0..NUM_MODES-1
//   Mode_Changed  one-cycle pulse when Mode takes a new value
//   Speed_Lvl     current speed level, 0..3
//   Step_Tick     one-cycle step pulse for the sequencer
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned TICK_DIV_BASE   = DEF_TICK_DIV_BASE,
    parameter int unsigned NUM_MODES       = 2
) (
    input  logic              Clk_50MHz,
    input  logic              Rst_OnBoard,
    input  logic              Btn_Mode_n,
    input  logic              Btn_Speed_n,
    output logic [MODE_W-1:0] Mode,
    output logic              Mode_Changed,
    output logic [SPEED_W-1:0] Speed_Lvl,
    output logic              Step_Tick
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV_BASE + 1);
    localparam mode_t  MODE_LAST  = MODE_W'(NUM_MODES - 1);
    localparam speed_t SPEED_LAST = SPEED_W'(SPEED_LVLS - 1);

    logic             mode_press;
    logic             speed_press;
    logic             div_clear;
    logic [DIV_W-1:0] period_last;

    mode_t            mode_q, mode_d;
    speed_t           speed_q, speed_d;
    logic             changed_q, changed_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_mode_db (
        .clk_i   (Clk_50MHz),
        .rst_i   (Rst_OnBoard),
        .btn_n_i (Btn_Mode_n),
        .press_o (mode_press)
    );

`ifdef LED_SPEED_SEL_EN
    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_speed_db (
        .clk_i   (Clk_50MHz),
        .rst_i   (Rst_OnBoard),
        .btn_n_i (Btn_Speed_n),
        .press_o (speed_press)
    );
`else
    logic unused_btn_speed;
    assign unused_btn_speed = Btn_Speed_n;
    assign speed_press      = 1'b0;
`endif

    // Each speed level halves the step period.
    assign period_last = DIV_W'(TICK_DIV_BASE >> speed_q) - DIV_W'(1);
    assign div_clear   = mode_press | speed_press;

    // Mode/speed/divider state registers.
    always_ff @(posedge Clk_50MHz or posedge Rst_OnBoard) begin
        if (Rst_OnBoard) begin
            mode_q    <= '0;
            speed_q   <= '0;
            changed_q <= 1'b0;
            div_q     <= '0;
            tick_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            speed_q   <= speed_d;
            changed_q <= changed_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
        end
    end

    // Next mode/speed on press; divider restarts a full period after any change.
    always_comb begin
        mode_d    = mode_q;
        speed_d   = speed_q;
        changed_d = mode_press;
        div_d     = div_q + DIV_W'(1);
        tick_d    = 1'b0;
        if (mode_press) begin
            mode_d = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);
        end
        if (speed_press) begin
            speed_d = (speed_q == SPEED_LAST) ? '0 : speed_q + SPEED_W'(1);
        end
        if (div_clear) begin
            div_d = '0;
        end else if (div_q == period_last) begin
            div_d  = '0;
            tick_d = 1'b1;
        end
    end

    assign Mode         = mode_q;
    assign Speed_Lvl    = speed_q;
    assign Mode_Changed = changed_q;
    assign Step_Tick    = tick_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with small debounce/divider constants.
module tb_led_pattern_ctrl;

    localparam int unsigned DEB  = 4;
    localparam int unsigned BASE = 16;
    localparam int unsigned NM   = 2;
`ifdef LED_SPEED_SEL_EN
    localparam int SPD_EN = 1;
`else
    localparam int SPD_EN = 0;
`endif

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       btn_m = 1'b1;
    logic       btn_s = 1'b1;
    logic [1:0] mode;
    logic       mode_chg;
    logic [1:0] speed;
    logic       tick;

    led_pattern_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .TICK_DIV_BASE   (BASE),
        .NUM_MODES       (NM)
    ) dut (
        .Clk_50MHz    (clk),
        .Rst_OnBoard  (rst),
        .Btn_Mode_n   (btn_m),
        .Btn_Speed_n  (btn_s),
        .Mode         (mode),
        .Mode_Changed (mode_chg),
        .Speed_Lvl    (speed),
        .Step_Tick    (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ml;      // mode button low cycles
        int sl;      // speed button low cycles
        int bn;      // 1: bounce pattern on mode button
        int e_mode;
        int e_spd;
        int e_mc;    // expected Mode_Changed pulses
        int e_per;   // expected Step_Tick spacing
    } vec_t;

    vec_t  tbl[9];
    string nm[9];

    int n_vec = 0;
    int n_err = 0;
    int mc_cnt = 0;
    int clash = 0;

    always @(negedge clk) begin
        if (mode_chg) mc_cnt++;
        if (mode_chg && tick) clash++;
    end

    function automatic vec_t mk(int ml, int sl, int bn, int em, int es, int emc, int ep);
        vec_t v;
        v.ml = ml; v.sl = sl; v.bn = bn;
        v.e_mode = em; v.e_spd = es; v.e_mc = emc; v.e_per = ep;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int ml, input int sl, input int bn);
        int n;
        if (bn != 0) begin
            for (int k = 0; k < 2; k++) begin
                btn_m = 1'b0; cyc(2);
                btn_m = 1'b1; cyc(2);
            end
        end else begin
            n = (ml > sl) ? ml : sl;
            for (int i = 0; i < n; i++) begin
                btn_m = (i < ml) ? 1'b0 : 1'b1;
                btn_s = (i < sl) ? 1'b0 : 1'b1;
                cyc(1);
            end
            btn_m = 1'b1;
            btn_s = 1'b1;
        end
    endtask

    // Spacing between two consecutive ticks; -1 on timeout.
    task automatic measure(output int p);
        int w;
        w = 0;
        while (!tick && w < 200) begin cyc(1); w++; end
        if (!tick) begin
            p = -1;
        end else begin
            p = 0;
            do begin cyc(1); p++; end while (!tick && p < 200);
            if (!tick) p = -1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int mc0;
        int w;

        tbl[0] = mk(20, 0, 0, 0, 0, 1, 16);                               nm[0] = "mode_wrap";
        tbl[1] = mk(3, 0, 0, 0, 0, 0, 16);                                nm[1] = "mode_glitch3";
        tbl[2] = mk(0, 0, 1, 0, 0, 0, 16);                                nm[2] = "mode_bounce";
        tbl[3] = mk(0, 20, 0, 0, SPD_EN ? 1 : 0, 0, SPD_EN ? 8 : 16);     nm[3] = "speed1";
        tbl[4] = mk(0, 20, 0, 0, SPD_EN ? 2 : 0, 0, SPD_EN ? 4 : 16);     nm[4] = "speed2";
        tbl[5] = mk(0, 20, 0, 0, SPD_EN ? 3 : 0, 0, SPD_EN ? 2 : 16);     nm[5] = "speed3";
        tbl[6] = mk(0, 20, 0, 0, 0, 0, 16);                               nm[6] = "speed_wrap";
        tbl[7] = mk(20, 0, 0, 1, 0, 1, 16);                               nm[7] = "mode1";
        tbl[8] = mk(0, 20, 0, 1, SPD_EN ? 1 : 0, 0, SPD_EN ? 8 : 16);     nm[8] = "speed_in_mode1";

        // Reset state
        cyc(3);
        chk("rst.mode", int'(mode), 0);
        chk("rst.speed", int'(speed), 0);
        chk("rst.mode_changed", int'(mode_chg), 0);
        chk("rst.tick", int'(tick), 0);

        // First tick lands on the 16th post-reset edge, then every 16
        rst = 1'b0;
        cyc(15);
        chk("first_tick.early", int'(tick), 0);
        cyc(1);
        chk("first_tick", int'(tick), 1);
        measure(p);
        chk("idle_period", p, 16);

        // Mode press latency: Mode updates 7 edges after the first low sample
        cyc(3);
        mc0 = mc_cnt;
        btn_m = 1'b0;
        cyc(7);
        chk("lat.mode_before", int'(mode), 0);
        cyc(1);
        chk("lat.mode", int'(mode), 1);
        chk("lat.mode_changed", int'(mode_chg), 1);
        chk("lat.tick_gated", int'(tick), 0);
        cyc(1);
        chk("lat.mode_changed_1cyc", int'(mode_chg), 0);
        cyc(14);
        chk("lat.tick_early", int'(tick), 0);
        cyc(1);
        chk("lat.tick_after_change", int'(tick), 1);
        btn_m = 1'b1;
        cyc(12);
        chk("lat.mc_pulses", mc_cnt - mc0, 1);

        // Table-driven presses, glitches and speed steps
        for (int i = 0; i < 9; i++) begin
            mc0 = mc_cnt;
            drive(tbl[i].ml, tbl[i].sl, tbl[i].bn);
            cyc(12);
            chk({nm[i], ".mode"}, int'(mode), tbl[i].e_mode);
            chk({nm[i], ".speed"}, int'(speed), tbl[i].e_spd);
            chk({nm[i], ".mc_pulses"}, mc_cnt - mc0, tbl[i].e_mc);
            measure(p);
            chk({nm[i], ".period"}, p, tbl[i].e_per);
        end

        // Both buttons on the same edge
        mc0 = mc_cnt;
        btn_m = 1'b0;
        btn_s = 1'b0;
        cyc(7);
        chk("both.mode_before", int'(mode), 1);
        cyc(1);
        chk("both.mode", int'(mode), 0);
        chk("both.speed", int'(speed), SPD_EN ? 2 : 0);
        chk("both.mode_changed", int'(mode_chg), 1);
        chk("both.tick_gated", int'(tick), 0);
        cyc(13);
        btn_m = 1'b1;
        btn_s = 1'b1;
        cyc(12);
        chk("both.mc_pulses", mc_cnt - mc0, 1);

        drive(20, 0, 0);
        cyc(12);
        chk("pre_rst.mode", int'(mode), 1);
        chk("pre_rst.speed", int'(speed), SPD_EN ? 2 : 0);

        // Asynchronous reset while a tick is high
        w = 0;
        while (!tick && w < 50) begin cyc(1); w++; end
        chk("pre_rst.tick", int'(tick), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst.mode", int'(mode), 0);
        chk("async_rst.speed", int'(speed), 0);
        chk("async_rst.mode_changed", int'(mode_chg), 0);
        chk("async_rst.tick", int'(tick), 0);

        // Button held through reset release is not a press
        btn_m = 1'b0;
        cyc(3);
        rst = 1'b0;
        mc0 = mc_cnt;
        cyc(30);
        chk("held.mode", int'(mode), 0);
        chk("held.mc_pulses", mc_cnt - mc0, 0);
        btn_m = 1'b1;
        cyc(15);
        drive(20, 0, 0);
        cyc(12);
        chk("repress.mode", int'(mode), 1);
        chk("repress.mc_pulses", mc_cnt - mc0, 1);

        chk("tick_vs_mode_changed", clash, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
